// File: rtl/ikbd_serial_tx.sv
// IKBD reply byte FIFO and 8N1 serialiser that drives the ACIA receive pin.
// Also reports FIFO fill level and a sticky overflow flag to the io controller.
module ikbd_serial_tx #(
  parameter int CLK_DIV  = 4096,
  parameter int FIFO_AW  = 4,
  parameter int GAP_BITS = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         din,
  input  logic               din_strobe,
  input  logic               flush,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               fifo_full,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GW    = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;

  localparam logic [TW-1:0]    TIMER_LOAD = TW'(CLK_DIV - 1);
  localparam logic [GW-1:0]    GAP_LOAD   = GW'(GAP_BITS);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic               fifo_empty;
  logic               full_int;
  logic               push_ok;
  logic               push_drop;
  logic               pop;
  logic [7:0]         head;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               bit_end;
  logic               take_next;

  assign fifo_empty = (count_q == '0);
  assign full_int   = (count_q == COUNT_FULL);
  assign head       = mem[rd_ptr];

  // A pop on the same edge frees a slot, so a write into a full FIFO is still legal then.
  assign push_ok   = din_strobe & ~flush & (~full_int | pop);
  assign push_drop = din_strobe & ~flush & full_int & ~pop;

  // FIFO control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FIFO storage carries data only and needs no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
    end
  end

  // The byte is latched at pop, so a later flush cannot disturb the frame in flight.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    take_next = 1'b0;
    bit_end   = (timer_q == '0);

    if (state_q != IDLE) begin
      timer_d = bit_end ? TIMER_LOAD : timer_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        take_next = 1'b1;
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (GAP_BITS > 0) begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            take_next = 1'b1;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (gap_q == GW'(1)) begin
            take_next = 1'b1;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Shared end-of-frame decision: chain straight into the next start bit or go idle.
    if (take_next) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = head;
        tx_d    = 1'b0;
        timer_d = TIMER_LOAD;
        state_d = START;
      end else begin
        tx_d    = 1'b1;
        timer_d = '0;
        state_d = IDLE;
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign fifo_count = count_q;
  assign fifo_full  = full_int;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ikbd_serial_tx.sv
// Directed bench for ikbd_serial_tx: frame shape, FIFO accounting, flush,
// idle gaps and asynchronous reset, with an 8N1 receiver model on the line.
module tb_ikbd_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_strobe;
  logic       flush;

  logic       tx0, busy0, full0, ovf0;
  logic [2:0] cnt0;
  logic       tx1, busy1, full1, ovf1;
  logic [4:0] cnt1;

  always #5 clk = ~clk;

  ikbd_serial_tx #(.CLK_DIV(16), .FIFO_AW(2), .GAP_BITS(0)) u0 (
    .clk(clk), .reset_n(rst_n), .din(din), .din_strobe(din_strobe), .flush(flush),
    .tx(tx0), .busy(busy0), .fifo_count(cnt0), .fifo_full(full0), .overflow(ovf0)
  );

  ikbd_serial_tx #(.CLK_DIV(16), .FIFO_AW(4), .GAP_BITS(2)) u1 (
    .clk(clk), .reset_n(rst_n), .din(din), .din_strobe(din_strobe), .flush(flush),
    .tx(tx1), .busy(busy1), .fifo_count(cnt1), .fifo_full(full1), .overflow(ovf1)
  );

  typedef struct packed {
    logic [7:0] din;
    logic       stb;
    logic       fl;
    logic [2:0] cnt;
    logic       full;
    logic       ovf;
  } row_t;

  typedef struct packed {
    logic [7:0] din;
    logic [9:0] frame;
  } fvec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       err;
  } rxf_t;

  row_t  rows [20];
  fvec_t fv [4];
  rxf_t  rx_q [$];
  time   rx_t [$];
  logic  tr [352];
  logic  bt [352];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // 8N1 receiver model on u0: samples mid-bit, flags bad start/stop levels
  initial begin : rx_model
    logic [7:0] b;
    logic       e;
    time        t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx0 === 1'b0) begin
        t = $time;
        repeat (8) @(negedge clk);
        e = (tx0 !== 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx0;
        end
        repeat (16) @(negedge clk);
        if (tx0 !== 1'b1) e = 1'b1;
        rx_q.push_back({b, e});
        rx_t.push_back(t);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench exceeded its time limit");
  end

  task automatic strobe(input logic [7:0] b);
    @(posedge clk); #1;
    din        = b;
    din_strobe = 1'b1;
    @(posedge clk); #1;
    din_strobe = 1'b0;
  endtask

  task automatic apply_row(input int i);
    din        = rows[i].din;
    din_strobe = rows[i].stb;
    flush      = rows[i].fl;
    @(posedge clk); #1;
    din_strobe = 1'b0;
    flush      = 1'b0;
    check($sformatf("row%0d_count", i), cnt0, rows[i].cnt);
    check($sformatf("row%0d_full", i), full0, rows[i].full);
    check($sformatf("row%0d_ovf", i), ovf0, rows[i].ovf);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_row(i);
  endtask

  task automatic record(input int n, input logic which);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tr[c] = which ? tx1 : tx0;
      bt[c] = which ? busy1 : busy0;
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_frames"}, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy0 !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_wait", busy0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp [6], input int n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("%s_byte%0d", name, i), rx_q[i].b, exp[i]);
        check($sformatf("%s_err%0d", name, i), rx_q[i].err, 1'b0);
      end
    end
  endtask

  initial begin
    logic [7:0] exp_b [6];
    int         mism;
    logic       e;

    rows = '{
      '{8'h12, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0},
      '{8'h34, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0},
      '{8'h56, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0},
      '{8'h21, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0},
      '{8'h22, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0},
      '{8'h23, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0},
      '{8'h24, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0},
      '{8'h25, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1},
      '{8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1},
      '{8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0},
      '{8'h77, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0},
      '{8'h41, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0},
      '{8'h42, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0},
      '{8'h43, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0},
      '{8'h44, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0},
      '{8'h45, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0},
      '{8'h90, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0},
      '{8'h91, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0},
      '{8'h92, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0},
      '{8'h93, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0}
    };
    // frame bit c = line level during bit time c: start, d0..d7, stop
    fv = '{
      '{8'hA5, 10'b1101001010},
      '{8'h00, 10'b1000000000},
      '{8'hFF, 10'b1111111110},
      '{8'h3C, 10'b1001111000}
    };

    rst_n      = 1'b0;
    din        = 8'h00;
    din_strobe = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx0", tx0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_cnt0", cnt0, 3'd0);
    check("rst_full0", full0, 1'b0);
    check("rst_ovf0", ovf0, 1'b0);
    check("rst_tx1", tx1, 1'b1);
    check("rst_cnt1", cnt1, 5'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_busy0", busy0, 1'b0);

    // exact frame shape and busy timing for several bytes
    for (int v = 0; v < 4; v++) begin
      rx_q.delete();
      rx_t.delete();
      strobe(fv[v].din);
      check($sformatf("f%0d_pre_tx", v), tx0, 1'b1);
      check($sformatf("f%0d_pre_cnt", v), cnt0, 3'd1);
      @(posedge clk); #1;
      check($sformatf("f%0d_start_edge", v), tx0, 1'b0);
      record(161, 1'b0);
      mism = 0;
      for (int c = 0; c < 160; c++) if (tr[c] !== fv[v].frame[c / 16]) mism++;
      if (tr[160] !== 1'b1) mism++;
      check($sformatf("f%0d_shape_mismatches", v), mism, 0);
      check($sformatf("f%0d_busy_last", v), bt[159], 1'b1);
      check($sformatf("f%0d_busy_after", v), bt[160], 1'b0);
      check($sformatf("f%0d_rx_count", v), rx_q.size(), 1);
      if (rx_q.size() > 0) check($sformatf("f%0d_rx_byte", v), rx_q[0].b, fv[v].din);
    end

    // back-to-back frames, no idle cycle between stop and next start
    @(posedge clk); #1;
    rx_q.delete();
    rx_t.delete();
    run_rows(0, 2);
    wait_frames(3, 700, "b2b");
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00};
    check_bytes("b2b", exp_b, 3);
    if (rx_t.size() >= 3) begin
      check("b2b_period1", 32'(rx_t[1] - rx_t[0]), 32'd1600);
      check("b2b_period2", 32'(rx_t[2] - rx_t[1]), 32'd1600);
    end
    wait_idle(300);

    // overflow while a frame is held in progress
    rx_q.delete();
    rx_t.delete();
    strobe(8'h11);
    @(posedge clk); #1;
    run_rows(3, 8);
    wait_frames(5, 1200, "ovf");
    exp_b = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h00};
    check_bytes("ovf", exp_b, 5);
    wait_idle(300);
    check("ovf_sticky", ovf0, 1'b1);
    run_rows(9, 10);
    repeat (3) @(posedge clk);
    #1;
    check("flush_write_no_frame", busy0, 1'b0);

    // write into a full FIFO on the exact pop edge at the end of a stop bit
    rx_q.delete();
    rx_t.delete();
    strobe(8'h31);
    @(posedge clk); #1;
    run_rows(11, 14);
    repeat (155) @(posedge clk);
    #1;
    run_rows(15, 15);
    check("popedge_restart_tx", tx0, 1'b0);
    wait_frames(6, 1300, "popedge");
    exp_b = '{8'h31, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    check_bytes("popedge", exp_b, 6);
    wait_idle(300);

    // flush plus strobe during the data phase of 0x81
    rx_q.delete();
    rx_t.delete();
    strobe(8'h81);
    @(posedge clk); #1;
    run_rows(16, 18);
    repeat (40) @(posedge clk);
    #1;
    run_rows(19, 19);
    wait_frames(1, 300, "flushmid");
    exp_b = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_bytes("flushmid", exp_b, 1);
    mism = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) mism++;
    end
    check("flushmid_quiet_cycles", mism, 0);
    check("flushmid_rx_total", rx_q.size(), 1);
    check("flushmid_busy", busy0, 1'b0);
    check("flushmid_ovf", ovf0, 1'b0);

    // idle gap between frames on the GAP_BITS=2 instance, then a mid-frame reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    strobe(8'hFF);
    din        = 8'h00;
    din_strobe = 1'b1;
    @(posedge clk); #1;
    din_strobe = 1'b0;
    check("gap_start_edge", tx1, 1'b0);
    record(352, 1'b1);
    mism = 0;
    for (int c = 0; c < 352; c++) begin
      e = (c < 16) ? 1'b0 : (c < 192) ? 1'b1 : (c < 336) ? 1'b0 : 1'b1;
      if (tr[c] !== e) mism++;
    end
    check("gap_shape_mismatches", mism, 0);
    check("gap_busy_in_gap", bt[180], 1'b1);
    strobe(8'h5A);
    strobe(8'h6B);
    repeat (50) @(posedge clk);
    #3;
    check("midrst_pre_tx", tx1, 1'b0);
    check("midrst_pre_cnt", cnt1, 5'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx1, 1'b1);
    check("midrst_cnt", cnt1, 5'd0);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_ovf", ovf1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("postrst_tx", tx1, 1'b1);
    check("postrst_busy", busy1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
